// File: rtl/road_pkg.sv
// Shared definitions for the 8x8 dot-matrix scan bus: geometry, pin polarity
// and the frame bit layout used by every block that reads or drives the panel.
package road_pkg;

  localparam int unsigned MATRIX_N = 8;

  // Row lines sink current (active-low), column lines source it (active-high).
  localparam logic ROW_ACTIVE = 1'b0;
  localparam logic COL_LIT    = 1'b1;

  typedef logic [MATRIX_N*MATRIX_N-1:0] frame_t;

  function automatic int unsigned pix_idx(input int unsigned r, input int unsigned c);
    return r * MATRIX_N + c;
  endfunction

endpackage

// File: rtl/dot_matrix_capture_scan_window_timer.sv
// Capture window counter: advances on enabled cycles and flags the last
// sample of each WINDOW-cycle window so the capture logic can publish.
module scan_window_timer
  import road_pkg::*;
#(
  parameter int unsigned WINDOW = 200000,
  parameter int unsigned CNT_W  = 18
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  output logic [CNT_W-1:0] cnt,
  output logic             last_sample
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             at_end;

  assign at_end      = (cnt_q == CNT_W'(WINDOW - 1));
  assign last_sample = enable & at_end;
  assign cnt         = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (enable) begin
      if (at_end) cnt_d = '0;
      else        cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/dot_matrix_capture.sv
// Reconstructs the 8x8 panel image by ORing sampled row/col pixels over a
// fixed window and publishing the result as a 64-bit frame.
module dot_matrix_capture
  import road_pkg::*;
#(
  parameter int unsigned WINDOW = 200000,
  parameter int unsigned CNT_W  = 18,
  parameter int unsigned ERR_W  = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [7:0]       row,
  input  logic [7:0]       col,
  input  logic             enable,
  output logic [63:0]      frame,
  output logic             frame_valid,
  output logic             frame_changed,
  output logic [15:0]      frame_count,
  output logic [ERR_W-1:0] multi_row_err,
  input  logic [2:0]       qrow,
  input  logic [2:0]       qcol,
  output logic             qbit
);

  logic [CNT_W-1:0] cnt;
  logic             last_sample;

  scan_window_timer #(
    .WINDOW (WINDOW),
    .CNT_W  (CNT_W)
  ) u_timer (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .cnt         (cnt),
    .last_sample (last_sample)
  );

  frame_t           acc_q,     acc_d;
  frame_t           frame_q,   frame_d;
  logic             valid_q,   valid_d;
  logic             changed_q, changed_d;
  logic [15:0]      count_q,   count_d;
  logic [ERR_W-1:0] err_q,     err_d;

  frame_t     hit;
  frame_t     closing;
  logic [7:0] rows_low;
  logic       multi_row;

  always_comb begin
    hit = '0;
    for (int r = 0; r < int'(MATRIX_N); r++) begin
      for (int c = 0; c < int'(MATRIX_N); c++) begin
        hit[pix_idx(r, c)] = (row[r] == ROW_ACTIVE) && (col[c] == COL_LIT);
      end
    end
  end

  // Two or more rows low: clearing the lowest set bit still leaves one set.
  assign rows_low  = ~row;
  assign multi_row = |(rows_low & (rows_low - 8'd1));
  assign closing   = acc_q | hit;

  // frame_valid is a one-cycle strobe with no back-pressure: consumers must
  // take frame/frame_changed in the cycle it is high.
  always_comb begin
    acc_d     = acc_q;
    frame_d   = frame_q;
    valid_d   = 1'b0;
    changed_d = 1'b0;
    count_d   = count_q;
    err_d     = err_q;
    if (enable) begin
      if (last_sample) begin
        frame_d   = closing;
        acc_d     = '0;
        valid_d   = 1'b1;
        changed_d = (closing != frame_q);
        count_d   = count_q + 16'd1;
      end else begin
        acc_d = closing;
      end
      if (multi_row && (col != 8'h00) && (err_q != '1)) begin
        err_d = err_q + ERR_W'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_q     <= '0;
      frame_q   <= '0;
      valid_q   <= 1'b0;
      changed_q <= 1'b0;
      count_q   <= '0;
      err_q     <= '0;
    end else begin
      acc_q     <= acc_d;
      frame_q   <= frame_d;
      valid_q   <= valid_d;
      changed_q <= changed_d;
      count_q   <= count_d;
      err_q     <= err_d;
    end
  end

  assign frame         = frame_q;
  assign frame_valid   = valid_q;
  assign frame_changed = changed_q;
  assign frame_count   = count_q;
  assign multi_row_err = err_q;
  assign qbit          = frame_q[{qrow, qcol}];

endmodule
